control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Fetch/decode/execute microsequencer for the 8-bit SAP-2 datapath: PC, MAR, RAM, IR, operand register, A, B, ALU, flags, output register.
- Each cycle it drives one registered control word onto the shared bus and registers; it also drives the ALU op select.
- Sits in `computer` between the IR/flags and every datapath load/output-enable; it replaces ad-hoc control decode.

Parameters:
- DATA_WIDTH, 8, width of opcode/operand bytes.
- CTRL_WIDTH, 16, width of control word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode_i  input  8  current IR contents.
- flag_zero_i  input  1  Z from flags register.
- flag_negative_i  input  1  N from flags register.
- ctrl_o  output  CTRL_WIDTH  control word, bit map in arch_defs_pkg.
- alu_op_o  output  3  ALU function select.
- instr_done_o  output  1  pulse in the last cycle of every instruction.
- illegal_o  output  1  pulse in the decode cycle of an unknown opcode.
- halt_o  output  1  sticky, high once HLT executes.

Behaviour:
- Outputs are registered; each output corresponds to the current state.
- Reset asserted (async): state S_RESET; ctrl_o=0, alu_op_o=0, instr_done_o=0, illegal_o=0, halt_o=0.
- The first cycle after release is S_RESET with all outputs 0; F0 follows.
- Fetch, 5 cycles, all instructions:
  - F0: PC_OE|MAR_LOAD
  - F1: RAM read wait, ctrl 0
  - F2: RAM_OE|IR_LOAD|PC_INC
  - F3: PC_OE|MAR_LOAD
  - F4: decode, ctrl 0; opcode_i is sampled here and latched for the whole execute phase.
- Execute steps:
  - NOP (0x00): none; F4 asserts instr_done_o, then F0.
  - LDA (0x10): E0 RAM_OE|OPND_LOAD|PC_INC; E1 OPND_OE|MAR_LOAD; E2 wait; E3 RAM_OE|A_LOAD. 4 cycles.
  - STA (0x20): E0, E1 as LDA; E2 A_OE|RAM_WE. 3 cycles.
  - ALU ops ADD 0x30, SUB 0x31, AND 0x32, OR 0x33, XOR 0x34: E0–E2 as LDA; E3 RAM_OE|B_LOAD; E4 compute, ctrl 0; E5 ALU_OE|A_LOAD|FLAGS_LOAD. 6 cycles.
  - ALU op select: alu_op_o = opcode[2:0], held E3–E5; 0 otherwise.
  - JMP 0x40, JZ 0x41, JN 0x42: E0 RAM_OE|OPND_LOAD|PC_INC; E1 OPND_OE|PC_LOAD if taken, else ctrl 0. Flags are sampled in E1. 2 cycles.
  - OUT (0xE0): E0 A_OE|OUT_LOAD. 1 cycle.
  - HLT (0xF0): S_HALT; halt_o=1, ctrl_o=0 forever until reset.
- Resulting totals: LDA 9 cycles, ALU ops 11; A and flags are latched at the edge ending E5.
- Unknown opcode: illegal_o pulses in F4, the opcode is treated as NOP, and execution continues at F0.
- instr_done_o is high exactly one cycle: the last execute step, or F4 for NOP/illegal.
- Invariants:
  - At most one *_OE bit set per cycle.
  - RAM_WE never coincides with RAM_OE.
  - Bit 15 is always 0.
- Reset mid-instruction: immediate return to S_RESET; no partial load completes after assertion.
- The 8-bit PC wraps 0xFF→0x00 in the datapath; this is not the sequencer's concern.

Decomposition:
- arch_defs_pkg gains:
  - opcode localparams;
  - control-bit indices 0 PC_OE, 1 PC_INC, 2 PC_LOAD, 3 MAR_LOAD, 4 RAM_OE, 5 RAM_WE, 6 IR_LOAD, 7 OPND_LOAD, 8 OPND_OE, 9 A_LOAD, 10 A_OE, 11 B_LOAD, 12 ALU_OE, 13 FLAGS_LOAD, 14 OUT_LOAD;
  - alu_op_t enum (ADD=0 .. XOR=4);
  - seq_state_t enum S_RESET, F0–F4, E0–E5, S_HALT.
- Structure:
  - One sub-module, opcode_decoder: combinational opcode → {class, exec_len, alu_op, legal}.
  - The FSM and output register stay in control_sequencer.

Test Plan:
- Release reset; opcode_i=0x10 from F2. Required response:
  - S_RESET;
  - F0 ctrl=0x0009, F2 ctrl=0x0052;
  - E3 ctrl=0x0210;
  - instr_done_o at cycle 9 after F0.
- OR (0x33) with Z=0, N=0. Required response:
  - E3 ctrl=0x0810, alu_op_o=3;
  - E5 ctrl=0x3200;
  - instr_done_o at cycle 11.
- JZ (0x41), Z=1 then Z=0. Required response:
  - taken: E1 ctrl=0x0104;
  - not taken: E1 ctrl=0x0000;
  - both: instr_done_o in E1.
- Opcode 0x77 → illegal_o=1 in F4, instr_done_o=1, next state F0 with ctrl=0x0009.
- HLT (0xF0) → halt_o=1 and ctrl_o=0 held for 50 cycles; reset low then high clears halt_o and restarts at F0.
- Reset low mid ALU-op E4 → ctrl_o=0 immediately, before the next edge; no FLAGS_LOAD is seen afterward.
- Every cycle of every scenario: bus-contention invariants hold.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: opcodes, control-word bit map, ALU ops, sequencer states.
package arch_defs_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h10;
  localparam logic [7:0] OP_STA = 8'h20;
  localparam logic [7:0] OP_ADD = 8'h30;
  localparam logic [7:0] OP_SUB = 8'h31;
  localparam logic [7:0] OP_AND = 8'h32;
  localparam logic [7:0] OP_OR  = 8'h33;
  localparam logic [7:0] OP_XOR = 8'h34;
  localparam logic [7:0] OP_JMP = 8'h40;
  localparam logic [7:0] OP_JZ  = 8'h41;
  localparam logic [7:0] OP_JN  = 8'h42;
  localparam logic [7:0] OP_OUT = 8'hE0;
  localparam logic [7:0] OP_HLT = 8'hF0;

  // Control-word bit indices; bit 15 is reserved and always 0.
  localparam int PC_OE      = 0;
  localparam int PC_INC     = 1;
  localparam int PC_LOAD    = 2;
  localparam int MAR_LOAD   = 3;
  localparam int RAM_OE     = 4;
  localparam int RAM_WE     = 5;
  localparam int IR_LOAD    = 6;
  localparam int OPND_LOAD  = 7;
  localparam int OPND_OE    = 8;
  localparam int A_LOAD     = 9;
  localparam int A_OE       = 10;
  localparam int B_LOAD     = 11;
  localparam int ALU_OE     = 12;
  localparam int FLAGS_LOAD = 13;
  localparam int OUT_LOAD   = 14;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;

  typedef enum logic [3:0] {
    S_RESET, F0, F1, F2, F3, F4, E0, E1, E2, E3, E4, E5, S_HALT
  } seq_state_t;

  typedef enum logic [3:0] {
    C_NOP, C_LDA, C_STA, C_ALU, C_JMP, C_JZ, C_JN, C_OUT, C_HLT
  } op_class_t;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier: instruction class, number of execute steps, ALU op, legality.
// Unknown opcodes decode as a zero-length NOP with legal low.
module opcode_decoder
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] opcode,
  output op_class_t             op_class,
  output logic [2:0]            exec_len,
  output alu_op_t               alu_op,
  output logic                  legal
);

  always_comb begin
    op_class = C_NOP;
    exec_len = 3'd0;
    alu_op   = ALU_ADD;
    legal    = 1'b1;
    case (opcode)
      DATA_WIDTH'(OP_NOP): ;
      DATA_WIDTH'(OP_LDA): begin op_class = C_LDA; exec_len = 3'd4; end
      DATA_WIDTH'(OP_STA): begin op_class = C_STA; exec_len = 3'd3; end
      DATA_WIDTH'(OP_ADD), DATA_WIDTH'(OP_SUB), DATA_WIDTH'(OP_AND),
      DATA_WIDTH'(OP_OR),  DATA_WIDTH'(OP_XOR): begin
        op_class = C_ALU;
        exec_len = 3'd6;
        alu_op   = alu_op_t'(opcode[2:0]);
      end
      DATA_WIDTH'(OP_JMP): begin op_class = C_JMP; exec_len = 3'd2; end
      DATA_WIDTH'(OP_JZ):  begin op_class = C_JZ;  exec_len = 3'd2; end
      DATA_WIDTH'(OP_JN):  begin op_class = C_JN;  exec_len = 3'd2; end
      DATA_WIDTH'(OP_OUT): begin op_class = C_OUT; exec_len = 3'd1; end
      DATA_WIDTH'(OP_HLT): op_class = C_HLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-2 fetch/decode/execute microsequencer driving one registered control word per cycle.
// Outputs are computed from the next state and registered, so they always describe the current state.
module control_sequencer
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] opcode_i,
  input  logic                  flag_zero_i,
  input  logic                  flag_negative_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [2:0]            alu_op_o,
  output logic                  instr_done_o,
  output logic                  illegal_o,
  output logic                  halt_o
);

  seq_state_t            state, state_n;
  logic [DATA_WIDTH-1:0] op_q, dec_in;
  op_class_t             cls;
  logic [2:0]            len;
  alu_op_t               aop;
  logic                  legal;
  logic [3:0]            step_cur, step_n;
  logic                  taken;
  logic [CTRL_WIDTH-1:0] ctrl_n;
  logic [2:0]            alu_n;
  logic                  done_n, illegal_n, halt_n;

  // Opcode is latched on the edge into F4, so F4's own outputs decode the live IR value.
  assign dec_in = (state == F3) ? opcode_i : op_q;

  opcode_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .opcode   (dec_in),
    .op_class (cls),
    .exec_len (len),
    .alu_op   (aop),
    .legal    (legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_RESET;
      op_q         <= '0;
      ctrl_o       <= '0;
      alu_op_o     <= 3'd0;
      instr_done_o <= 1'b0;
      illegal_o    <= 1'b0;
      halt_o       <= 1'b0;
    end else begin
      state        <= state_n;
      if (state == F3) op_q <= opcode_i;
      ctrl_o       <= ctrl_n;
      alu_op_o     <= alu_n;
      instr_done_o <= done_n;
      illegal_o    <= illegal_n;
      halt_o       <= halt_n;
    end
  end

  always_comb begin
    state_n   = state;
    ctrl_n    = '0;
    alu_n     = 3'd0;
    done_n    = 1'b0;
    illegal_n = 1'b0;
    halt_n    = 1'b0;
    step_cur  = 4'(state) - 4'(E0);
    taken     = 1'b0;

    case (state)
      S_RESET: state_n = F0;
      F0:      state_n = F1;
      F1:      state_n = F2;
      F2:      state_n = F3;
      F3:      state_n = F4;
      F4: begin
        if (cls == C_HLT)      state_n = S_HALT;
        else if (len == 3'd0)  state_n = F0;
        else                   state_n = E0;
      end
      E0, E1, E2, E3, E4, E5:
        state_n = (step_cur + 4'd1 == {1'b0, len}) ? F0 : seq_state_t'(4'(state) + 4'd1);
      default: state_n = S_HALT;
    endcase

    step_n = 4'(state_n) - 4'(E0);
    case (cls)
      C_JMP:   taken = 1'b1;
      C_JZ:    taken = flag_zero_i;
      C_JN:    taken = flag_negative_i;
      default: taken = 1'b0;
    endcase

    case (state_n)
      F0, F3: begin ctrl_n[PC_OE] = 1'b1; ctrl_n[MAR_LOAD] = 1'b1; end
      F2: begin ctrl_n[RAM_OE] = 1'b1; ctrl_n[IR_LOAD] = 1'b1; ctrl_n[PC_INC] = 1'b1; end
      F4: begin
        illegal_n = !legal;
        done_n    = (len == 3'd0) && (cls != C_HLT);
      end
      E0: begin
        if (cls == C_OUT) begin
          ctrl_n[A_OE] = 1'b1; ctrl_n[OUT_LOAD] = 1'b1;
        end else begin
          ctrl_n[RAM_OE] = 1'b1; ctrl_n[OPND_LOAD] = 1'b1; ctrl_n[PC_INC] = 1'b1;
        end
      end
      E1: begin
        if (cls == C_JMP || cls == C_JZ || cls == C_JN) begin
          ctrl_n[OPND_OE] = taken; ctrl_n[PC_LOAD] = taken;
        end else begin
          ctrl_n[OPND_OE] = 1'b1; ctrl_n[MAR_LOAD] = 1'b1;
        end
      end
      E2: if (cls == C_STA) begin ctrl_n[A_OE] = 1'b1; ctrl_n[RAM_WE] = 1'b1; end
      E3: begin
        ctrl_n[RAM_OE] = 1'b1;
        if (cls == C_ALU) ctrl_n[B_LOAD] = 1'b1;
        else              ctrl_n[A_LOAD] = 1'b1;
      end
      E5: begin ctrl_n[ALU_OE] = 1'b1; ctrl_n[A_LOAD] = 1'b1; ctrl_n[FLAGS_LOAD] = 1'b1; end
      S_HALT: halt_n = 1'b1;
      default: ;
    endcase

    if (state_n >= E0 && state_n <= E5) begin
      done_n = (step_n + 4'd1 == {1'b0, len});
      if (cls == C_ALU && step_n >= 4'd3) alu_n = aop;
    end
  end

endmodule
